// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm-clock time-setting path.
package alarm_pkg;

   localparam int unsigned BTN_CENTER = 0;
   localparam int unsigned BTN_UP     = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_DOWN   = 4;
   localparam int unsigned NUM_BTN    = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EDIT   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // v + s wrapped into 0..m-1; sum held in 33 bits so it cannot overflow
   function automatic logic [31:0] mod_add(input logic [31:0] v, input logic [31:0] s,
                                           input logic [31:0] m);
      logic [32:0] sum;
      sum = {1'b0, v} + {1'b0, s};
      if (sum >= {1'b0, m}) return 32'(sum - {1'b0, m});
      return 32'(sum);
   endfunction

   function automatic logic [31:0] mod_sub(input logic [31:0] v, input logic [31:0] s,
                                           input logic [31:0] m);
      if (v >= s) return v - s;
      return 32'({1'b0, v} + {1'b0, m} - {1'b0, s});
   endfunction

endpackage

// File: rtl/btn_repeat.sv
// One button: 2-flop synchroniser, press-edge detect and optional hold auto-repeat.
module btn_repeat #(
   parameter int unsigned RPT_DELAY = 500,
   parameter int unsigned RPT_RATE  = 100,
   parameter int unsigned CW        = 14,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic CLOCK_1ms,
   input  logic RESET,
   input  logic clr,
   input  logic btn,
   output logic press_c,
   output logic rep_c,
   output logic held
);

   logic          s1, s2, hist;
   logic          phase;
   logic [CW-1:0] cnt;
   logic          rpt_hit;

   assign held    = s2;
   assign press_c = s2 & ~hist;
   // cnt equals the number of cycles since the edge (or since the last repeat)
   assign rpt_hit = phase ? (cnt == CW'(RPT_RATE)) : (cnt == CW'(RPT_DELAY));
   assign rep_c   = REPEAT_EN && s2 && !press_c && rpt_hit;

   always_ff @(posedge CLOCK_1ms or posedge RESET) begin
      if (RESET) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         hist  <= 1'b0;
         phase <= 1'b0;
         cnt   <= '0;
      end else if (clr) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         hist  <= 1'b0;
         phase <= 1'b0;
         cnt   <= '0;
      end else begin
         s1   <= btn;
         s2   <= s1;
         hist <= s2;
         if (!s2) begin
            cnt   <= '0;
            phase <= 1'b0;
         end else if (press_c) begin
            cnt <= CW'(1);
         end else if (rep_c) begin
            cnt   <= CW'(1);
            phase <= 1'b1;
         end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/time_set_editor.sv
// Modular time-setting editor: digit select, step up/down with wrap, commit handshake, timeout.
module time_set_editor
   import alarm_pkg::*;
#(
   parameter int unsigned          W         = 12,
   parameter int unsigned          MOD       = 3600,
   parameter int unsigned          DIGITS    = 4,
   parameter logic [DIGITS*W-1:0]  STEPS     = {12'd600, 12'd60, 12'd10, 12'd1},
   parameter int unsigned          RPT_DELAY = 500,
   parameter int unsigned          RPT_RATE  = 100,
   parameter int unsigned          TIMEOUT   = 10000
) (
   input  logic              CLOCK_1ms,
   input  logic              RESET,
   input  logic              CLOCK_1s,
   input  logic              ENABLE,
   input  logic [W-1:0]      TIME_CURR,
   input  logic [4:0]        BTN,
   output logic [W-1:0]      TIME_SET,
   output logic [DIGITS-1:0] SEL_ONEHOT,
   output logic [DIGITS-1:0] BLANK_MASK,
   output logic              EDITING,
   output logic              COMMIT_VALID,
   input  logic              COMMIT_READY,
   output logic              CANCEL_PULSE,
   output logic              CLOCK_RUN
);

   localparam int unsigned CMAX = (RPT_DELAY > TIMEOUT) ? RPT_DELAY : TIMEOUT;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned SW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state, state_n;
   logic [W-1:0]        time_set, time_set_n, entry, entry_n;
   logic [SW-1:0]       sel, sel_n;
   logic [DIGITS-1:0]   sel_oh, sel_oh_n;
   logic [CW-1:0]       to_cnt, to_cnt_n;
   logic                editing, valid, cancel, run, run_n, cancel_n;
   logic                en_q, en_rise, en_fall;
   logic [W-1:0]        step;

   logic [NUM_BTN-1:0]  press_c, rep_c, held;
   logic                both, up_evt, dn_evt, any_evt, unused_bits;

   assign en_rise = ENABLE & ~en_q;
   assign en_fall = ~ENABLE & en_q;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_repeat #(
         .RPT_DELAY (RPT_DELAY),
         .RPT_RATE  (RPT_RATE),
         .CW        (CW),
         .REPEAT_EN (gi == BTN_UP || gi == BTN_DOWN)
      ) u_btn (
         .CLOCK_1ms (CLOCK_1ms),
         .RESET     (RESET),
         .clr       (en_rise),
         .btn       (BTN[gi]),
         .press_c   (press_c[gi]),
         .rep_c     (rep_c[gi]),
         .held      (held[gi])
      );
   end

   // UP and DOWN held together cancel each other out entirely
   assign both        = held[BTN_UP] & held[BTN_DOWN];
   assign up_evt      = (press_c[BTN_UP] | rep_c[BTN_UP]) & ~both;
   assign dn_evt      = (press_c[BTN_DOWN] | rep_c[BTN_DOWN]) & ~both;
   assign any_evt     = press_c[BTN_CENTER] | press_c[BTN_LEFT] | press_c[BTN_RIGHT] | up_evt | dn_evt;
   assign unused_bits = ^{held[BTN_CENTER], held[BTN_LEFT], held[BTN_RIGHT],
                          rep_c[BTN_CENTER], rep_c[BTN_LEFT], rep_c[BTN_RIGHT]};

   assign step = STEPS[sel*W +: W];

   always_comb begin
      state_n    = state;
      time_set_n = time_set;
      entry_n    = entry;
      sel_n      = sel;
      to_cnt_n   = to_cnt;
      cancel_n   = 1'b0;
      run_n      = run;
      case (state)
         IDLE: begin
            if (en_rise) begin
               state_n    = EDIT;
               time_set_n = TIME_CURR;
               entry_n    = TIME_CURR;
               sel_n      = '0;
               to_cnt_n   = '0;
            end
         end
         EDIT: begin
            if (any_evt)              to_cnt_n = '0;
            else if (to_cnt != '1)    to_cnt_n = to_cnt + CW'(1);
            if (en_fall || to_cnt >= CW'(TIMEOUT)) begin
               time_set_n = entry;
               cancel_n   = 1'b1;
               state_n    = IDLE;
            end else if (press_c[BTN_CENTER]) begin
               state_n = COMMIT;
            end else if (press_c[BTN_LEFT]) begin
               sel_n = (sel == SW'(DIGITS - 1)) ? '0 : sel + SW'(1);
            end else if (press_c[BTN_RIGHT]) begin
               sel_n = (sel == '0) ? SW'(DIGITS - 1) : sel - SW'(1);
            end else if (up_evt) begin
               time_set_n = W'(mod_add(32'(time_set), 32'(step), 32'(MOD)));
            end else if (dn_evt) begin
               time_set_n = W'(mod_sub(32'(time_set), 32'(step), 32'(MOD)));
            end
         end
         COMMIT: begin
            if (COMMIT_READY) begin
               run_n   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      sel_oh_n = DIGITS'(1) << sel_n;
   end

   always_ff @(posedge CLOCK_1ms or posedge RESET) begin
      if (RESET) begin
         state    <= IDLE;
         time_set <= '0;
         entry    <= '0;
         sel      <= '0;
         sel_oh   <= DIGITS'(1);
         to_cnt   <= '0;
         editing  <= 1'b0;
         valid    <= 1'b0;
         cancel   <= 1'b0;
         run      <= 1'b0;
         en_q     <= 1'b0;
      end else begin
         state    <= state_n;
         time_set <= time_set_n;
         entry    <= entry_n;
         sel      <= sel_n;
         sel_oh   <= sel_oh_n;
         to_cnt   <= to_cnt_n;
         editing  <= (state_n == EDIT);
         valid    <= (state_n == COMMIT);
         cancel   <= cancel_n;
         run      <= run_n;
         en_q     <= ENABLE;
      end
   end

   assign TIME_SET     = time_set;
   assign SEL_ONEHOT   = sel_oh;
   assign BLANK_MASK   = sel_oh & {DIGITS{~CLOCK_1s & editing}};
   assign EDITING      = editing;
   assign COMMIT_VALID = valid;
   assign CANCEL_PULSE = cancel;
   assign CLOCK_RUN    = run;

endmodule
